// File: rtl/sipo_frame_receiver.sv
// sipo_frame_receiver: strobe-qualified serial-to-parallel word assembler with a one-entry valid/ready holding register
module sipo_frame_receiver #(
  parameter int DATA_WIDTH = 8,
  parameter bit LSB_FIRST  = 1
) (
  input  logic                          Clk_In,
  input  logic                          Reset_In,
  input  logic                          Enable_In,
  input  logic                          Frame_Start_In,
  input  logic                          Serial_Data_In,
  output logic [DATA_WIDTH-1:0]         Parallel_Data_Out,
  output logic                          Data_Valid_Out,
  input  logic                          Data_Ready_In,
  output logic                          Busy_Out,
  output logic [$clog2(DATA_WIDTH)-1:0] Bit_Count_Out,
  output logic                          Overrun_Error_Out
);
  localparam int CW = $clog2(DATA_WIDTH);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] sr_q, sr_d, data_q, data_d, base, shifted;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  valid_q, valid_d, ovr_q, ovr_d;
  logic                  start, step, done, load;
  // Frame events: a start strobe always wins, clearing the partial word so it becomes bit 0
  always_comb begin
    start   = Enable_In && Frame_Start_In;
    step    = Enable_In && !Frame_Start_In && state_q == SHIFT;
    done    = step && cnt_q == CW'(DATA_WIDTH - 1);
    base    = start ? '0 : sr_q;
    shifted = LSB_FIRST ? {Serial_Data_In, base[DATA_WIDTH-1:1]}
                        : {base[DATA_WIDTH-2:0], Serial_Data_In};
    load    = done && (!valid_q || Data_Ready_In);
  end
  // State register
  always_ff @(posedge Clk_In or posedge Reset_In) begin
    if (Reset_In) state_q <= IDLE;
    else          state_q <= state_d;
  end
  // Next state: enter SHIFT on a start strobe, leave it on the edge that samples the last bit
  always_comb begin
    state_d = start ? SHIFT : done ? IDLE : state_q;
  end
  // FSM outputs
  always_comb begin
    Busy_Out = state_q == SHIFT;
  end
  // Datapath next state: shifter, bit counter, holding register, valid and sticky overrun
  always_comb begin
    sr_d    = (start || step) ? shifted : sr_q;
    cnt_d   = start ? CW'(1) : done ? '0 : step ? cnt_q + 1'b1 : cnt_q;
    data_d  = load ? shifted : data_q;
    valid_d = load || (valid_q && !Data_Ready_In);
    ovr_d   = ovr_q || (done && valid_q && !Data_Ready_In);
  end
  // Datapath registers
  always_ff @(posedge Clk_In or posedge Reset_In) begin
    if (Reset_In) begin
      sr_q    <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end
  assign Parallel_Data_Out = data_q;
  assign Data_Valid_Out    = valid_q;
  assign Bit_Count_Out     = cnt_q;
  assign Overrun_Error_Out = ovr_q;
endmodule

// File: doc/sipo_frame_receiver.md
Name: sipo_frame_receiver

Overview:
- Serial-In-Parallel-Out receiver that sits directly downstream of the 8-bit PISO shift register.
- Samples the LSB-first serial stream under a bit-enable strobe and reassembles DATA_WIDTH-bit words.
- Presents each completed word through a one-entry output holding register with a valid/ready handshake.
- Flags an overrun when a word completes while the previous word has not been consumed.

Parameters:
- DATA_WIDTH, 8: word length in bits (minimum 2).
- LSB_FIRST, 1: 1 means the first received bit lands in bit 0; 0 means it lands in bit DATA_WIDTH-1.

Ports:
- Clk_In  input  1  single clock; all state updates on posedge (half-cycle margin against the upstream negedge shifter).
- Reset_In  input  1  asynchronous, active-high reset.
- Enable_In  input  1  bit strobe; a serial bit is sampled only on edges where this is high.
- Frame_Start_In  input  1  marks the first bit of a frame; qualified by Enable_In.
- Serial_Data_In  input  1  serial data bit.
- Parallel_Data_Out  output  DATA_WIDTH  holding-register word.
- Data_Valid_Out  output  1  holding register contains an unconsumed word.
- Data_Ready_In  input  1  consumer accepts the word when this and Data_Valid_Out are both high at a posedge.
- Busy_Out  output  1  high while a frame is being assembled (SHIFT state).
- Bit_Count_Out  output  clog2(DATA_WIDTH)  number of bits captured in the current frame.
- Overrun_Error_Out  output  1  sticky overrun flag.

Behaviour:
- Reset (asynchronous, any time, including mid-frame):
  - State goes to IDLE; the partial frame is discarded.
  - All outputs and internal registers become 0: Parallel_Data_Out=0, Data_Valid_Out=0, Busy_Out=0, Bit_Count_Out=0, Overrun_Error_Out=0.
- IDLE:
  - Enable_In=1 and Frame_Start_In=1 samples Serial_Data_In as bit 0 of the frame, sets Bit_Count_Out=1 and moves to SHIFT.
  - All other inputs are ignored.
- SHIFT:
  - Each edge with Enable_In=1 and Frame_Start_In=0 samples one bit and increments Bit_Count_Out.
  - Edges with Enable_In=0 hold all state.
  - LSB_FIRST=1: shift register takes {Serial_Data_In, sr[W-1:1]}. LSB_FIRST=0: it takes {sr[W-2:0], Serial_Data_In}.
  - Frame_Start_In=1 with Enable_In=1 restarts the frame: the partial word is dropped, this bit becomes bit 0, Bit_Count_Out=1, and no error is raised.
- Word completion, on the enabled edge that samples bit DATA_WIDTH-1:
  - The assembled word, including the bit sampled on this edge, is evaluated for loading into the holding register.
  - State returns to IDLE and Bit_Count_Out returns to 0.
  - Latency: the word is visible on Parallel_Data_Out with Data_Valid_Out=1 immediately after that edge, i.e. zero extra cycles.
  - Back-to-back frames: Frame_Start_In on the very next enabled edge is accepted from IDLE.
- Holding register and handshake:
  - Load when Data_Valid_Out=0, or when Data_Valid_Out=1 and Data_Ready_In=1 on the same edge (simultaneous consume and load). In the latter case Data_Valid_Out stays 1 with the new word.
  - Consume without a new word: Data_Valid_Out drops to 0 after the edge. Parallel_Data_Out keeps its last value.
  - Overrun: Data_Valid_Out=1, Data_Ready_In=0 and a word completes. The new word is dropped, the old word is retained, and Overrun_Error_Out is set. It stays set until Reset_In.
- Parallel_Data_Out changes only on a load; it never changes while Data_Valid_Out=1 and Data_Ready_In=0.
- Busy_Out = (state == SHIFT).

Test Plan:
- Basic word: LSB_FIRST=1, Data_Ready_In=1. Drive Frame_Start_In on the first bit and serialize 0xA5 LSB-first (1,0,1,0,0,1,0,1) with Enable_In continuously high. Required: after the 8th edge Parallel_Data_Out=0xA5 and Data_Valid_Out=1 for exactly one cycle; Busy_Out is high for 7 cycles.
- Enable gaps: send 0x3C with Enable_In low for 2 cycles between each bit. Required: result 0x3C; Bit_Count_Out holds during gaps; completion occurs on the 8th enabled edge only.
- Backpressure/overrun:
  - Receive 0x11 and hold Data_Ready_In=0, then receive 0x22. Required: Parallel_Data_Out stays 0x11 and Overrun_Error_Out=1.
  - Then raise Data_Ready_In. Required: Data_Valid_Out falls; Overrun_Error_Out stays 1.
- Simultaneous consume/load: hold 0x55 valid, and assert Data_Ready_In on the same edge the bit that completes 0x66 is sampled. Required: Data_Valid_Out stays 1, Parallel_Data_Out=0x66, Overrun_Error_Out=0.
- Restart and reset mid-frame:
  - After 4 bits, reassert Frame_Start_In and send 0xF0. Required: output 0xF0, no error.
  - Assert Reset_In after 5 bits of a second frame. Required: all outputs 0 immediately; the next full frame 0x81 is received correctly.
- MSB-first parameter: LSB_FIRST=0, serial 1,0,0,0,0,0,0,1 then 0,0,0,0,1,1,1,1. Required: 0x81 then 0x0F.
